// File: rtl/lcd_pkg.sv
// Shared state codes, default panel timing and backlight step helpers for the LCD power sequencer.
package lcd_pkg;

  localparam logic [2:0] ST_OFF  = 3'd0;
  localparam logic [2:0] ST_RST  = 3'd1;
  localparam logic [2:0] ST_WAKE = 3'd2;
  localparam logic [2:0] ST_PRE  = 3'd3;
  localparam logic [2:0] ST_RAMP = 3'd4;
  localparam logic [2:0] ST_ON   = 3'd5;
  localparam logic [2:0] ST_DOWN = 3'd6;
  localparam logic [2:0] ST_POST = 3'd7;

  typedef enum logic [2:0] {
    S_OFF  = ST_OFF,
    S_RST  = ST_RST,
    S_WAKE = ST_WAKE,
    S_PRE  = ST_PRE,
    S_RAMP = ST_RAMP,
    S_ON   = ST_ON,
    S_DOWN = ST_DOWN,
    S_POST = ST_POST
  } lcd_state_e;

  localparam logic [23:0] DEF_T_RST   = 24'd120000;
  localparam logic [23:0] DEF_T_WAKE  = 24'd600000;
  localparam int unsigned DEF_N_PRE   = 4;
  localparam int unsigned DEF_N_POST  = 2;
  localparam logic [7:0]  DEF_BL_STEP = 8'd16;
  localparam logic [7:0]  DEF_BL_MAX  = 8'd255;

  // 9-bit sum so a step past the limit saturates instead of wrapping.
  function automatic logic [7:0] bl_up(input logic [7:0] duty,
                                       input logic [7:0] step,
                                       input logic [7:0] lim);
    logic [8:0] sum;
    sum = {1'b0, duty} + {1'b0, step};
    return (sum >= {1'b0, lim}) ? lim : sum[7:0];
  endfunction

  function automatic logic [7:0] bl_dn(input logic [7:0] duty,
                                       input logic [7:0] step);
    return (duty > step) ? (duty - step) : 8'd0;
  endfunction

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: free-running 8-bit counter compared against duty; output is a flop.
module lcd_bl_pwm (
  input  logic       CLK_SYS,
  input  logic       rst,
  input  logic [7:0] duty_i,
  output logic       pwm_o
);

  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_q, pwm_d;

  assign pwm_cnt_d = pwm_cnt_q + 8'd1;
  assign pwm_d     = (pwm_cnt_q < duty_i);

  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q <= 8'd0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/lcd_pwr_seq.sv
// LCD panel power sequencer: reset/wake delays, frame-counted timing lead-in/out and backlight ramp.
// All outputs come straight from flops; every control output is registered from the next state.
module lcd_pwr_seq
  import lcd_pkg::*;
#(
  parameter logic [23:0] T_RST   = DEF_T_RST,
  parameter logic [23:0] T_WAKE  = DEF_T_WAKE,
  parameter int unsigned N_PRE   = DEF_N_PRE,
  parameter int unsigned N_POST  = DEF_N_POST,
  parameter logic [7:0]  BL_STEP = DEF_BL_STEP,
  parameter logic [7:0]  BL_MAX  = DEF_BL_MAX
) (
  input  logic       CLK_SYS,
  input  logic       rst,
  input  logic       en,
  input  logic       vsync_n,
  output logic       lcd_rst_n,
  output logic       timing_en,
  output logic       bl_pwm,
  output logic       ready,
  output logic [2:0] state
);

  localparam logic [7:0] PRE_LAST  = (N_PRE  == 0) ? 8'd0 : 8'(N_PRE  - 1);
  localparam logic [7:0] POST_LAST = (N_POST == 0) ? 8'd0 : 8'(N_POST - 1);

  lcd_state_e  state_q, state_d;
  logic [23:0] dly_q, dly_d;
  logic [7:0]  frm_q, frm_d;
  logic [7:0]  duty_q, duty_d;
  logic        lcd_rst_n_q, lcd_rst_n_d;
  logic        timing_en_q, timing_en_d;
  logic        ready_q, ready_d;
  logic        vs_cur_q, vs_prev_q;
  logic        tick;
  logic [7:0]  duty_up, duty_dn;

  // Two-flop vsync history; one tick per falling edge.
  assign tick    = vs_prev_q & ~vs_cur_q;
  assign duty_up = bl_up(duty_q, BL_STEP, BL_MAX);
  assign duty_dn = bl_dn(duty_q, BL_STEP);

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    frm_d   = frm_q;
    duty_d  = duty_q;
    case (state_q)
      S_OFF: begin
        if (en) state_d = S_RST;
      end
      S_RST: begin
        if (!en)                           state_d = S_OFF;
        else if (dly_q == T_RST - 24'd1)   state_d = S_WAKE;
        else                               dly_d   = dly_q + 24'd1;
      end
      S_WAKE: begin
        if (!en)                           state_d = S_OFF;
        else if (dly_q == T_WAKE - 24'd1)  state_d = S_PRE;
        else                               dly_d   = dly_q + 24'd1;
      end
      S_PRE: begin
        if (!en)              state_d = S_OFF;
        else if (N_PRE == 0)  state_d = S_RAMP;
        else if (tick) begin
          if (frm_q == PRE_LAST) state_d = S_RAMP;
          else                   frm_d   = frm_q + 8'd1;
        end
      end
      S_RAMP: begin
        // Abort keeps the current duty so the ramp-down starts from where we are.
        if (!en) state_d = S_DOWN;
        else if (tick) begin
          duty_d = duty_up;
          if (duty_up == BL_MAX) state_d = S_ON;
        end
      end
      S_ON: begin
        if (!en) state_d = S_DOWN;
      end
      S_DOWN: begin
        if (duty_q == 8'd0) state_d = S_POST;
        else if (tick) begin
          duty_d = duty_dn;
          if (duty_dn == 8'd0) state_d = S_POST;
        end
      end
      S_POST: begin
        if (N_POST == 0) state_d = S_OFF;
        else if (tick) begin
          if (frm_q == POST_LAST) state_d = S_OFF;
          else                    frm_d   = frm_q + 8'd1;
        end
      end
      default: state_d = S_OFF;
    endcase

    // Counters restart on every state entry, so a tick on the transition cycle is not counted twice.
    if (state_d != state_q) begin
      dly_d = 24'd0;
      frm_d = 8'd0;
    end
    if (!(state_d inside {S_RAMP, S_ON, S_DOWN})) duty_d = 8'd0;

    lcd_rst_n_d = !(state_d inside {S_OFF, S_RST});
    timing_en_d = state_d inside {S_PRE, S_RAMP, S_ON, S_DOWN, S_POST};
    ready_d     = (state_d == S_ON);
  end

  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      state_q     <= S_OFF;
      dly_q       <= 24'd0;
      frm_q       <= 8'd0;
      duty_q      <= 8'd0;
      lcd_rst_n_q <= 1'b0;
      timing_en_q <= 1'b0;
      ready_q     <= 1'b0;
      vs_cur_q    <= 1'b1;
      vs_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      frm_q       <= frm_d;
      duty_q      <= duty_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      timing_en_q <= timing_en_d;
      ready_q     <= ready_d;
      vs_cur_q    <= vsync_n;
      vs_prev_q   <= vs_cur_q;
    end
  end

  lcd_bl_pwm u_bl_pwm (
    .CLK_SYS (CLK_SYS),
    .rst     (rst),
    .duty_i  (duty_q),
    .pwm_o   (bl_pwm)
  );

  assign lcd_rst_n = lcd_rst_n_q;
  assign timing_en = timing_en_q;
  assign ready     = ready_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lcd_pwr_seq.sv
// Directed bench for lcd_pwr_seq with short timing; duty is inferred from bl_pwm over 256-cycle windows.
module tb_lcd_pwr_seq;

  logic       CLK_SYS = 1'b0;
  logic       rst     = 1'b0;
  logic       en      = 1'b0;
  logic       vsync_n = 1'b1;
  logic       lcd_rst_n, timing_en, bl_pwm, ready;
  logic [2:0] state;

  int total  = 0;
  int bad    = 0;
  int te_cnt = 0;

  always #5 CLK_SYS = ~CLK_SYS;

  lcd_pwr_seq #(
    .T_RST   (24'd10),
    .T_WAKE  (24'd20),
    .N_PRE   (2),
    .N_POST  (1),
    .BL_STEP (8'd64),
    .BL_MAX  (8'd255)
  ) dut (
    .CLK_SYS   (CLK_SYS),
    .rst       (rst),
    .en        (en),
    .vsync_n   (vsync_n),
    .lcd_rst_n (lcd_rst_n),
    .timing_en (timing_en),
    .bl_pwm    (bl_pwm),
    .ready     (ready),
    .state     (state)
  );

  // 1000-cycle frames, vsync_n low for the first 8 cycles of each.
  initial begin
    forever begin
      repeat (992) @(negedge CLK_SYS);
      vsync_n = 1'b0;
      repeat (8) @(negedge CLK_SYS);
      vsync_n = 1'b1;
    end
  end

  always @(negedge CLK_SYS) if (timing_en) te_cnt <= te_cnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
    int n = 0;
    while (state !== tgt && n < budget) begin
      @(negedge CLK_SYS);
      n++;
    end
    chk(tag, {29'd0, state}, {29'd0, tgt});
  endtask

  task automatic after_tick();
    @(negedge vsync_n);
    repeat (10) @(negedge CLK_SYS);
  endtask

  task automatic pwm_hi(output int hi);
    hi = 0;
    repeat (256) begin
      @(negedge CLK_SYS);
      if (bl_pwm) hi++;
    end
  endtask

  int hi, n, te0;
  int up_duty[4]  = '{64, 128, 192, 255};
  int up_st[4]    = '{4, 4, 4, 5};
  int dn_duty[4]  = '{191, 127, 63, 0};
  int dn_st[4]    = '{6, 6, 6, 7};

  initial begin
    // Reset values
    repeat (3) @(negedge CLK_SYS);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_lcd_rst_n", {31'd0, lcd_rst_n}, 32'd0);
    chk("rst_timing_en", {31'd0, timing_en}, 32'd0);
    chk("rst_bl_pwm", {31'd0, bl_pwm}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);

    // Power-up: RST holds 10 edges (lcd_rst_n high in the 11th cycle counting RST entry as 1), WAKE 20
    en  = 1'b1;
    rst = 1'b1;
    wait_state(3'd1, 5, "enter_rst");
    n = 0;
    while (!lcd_rst_n && n < 100) begin @(negedge CLK_SYS); n++; end
    chk("rst_hold_len", n, 10);
    chk("wake_state", {29'd0, state}, 32'd2);
    chk("wake_te", {31'd0, timing_en}, 32'd0);
    n = 0;
    while (state !== 3'd3 && n < 100) begin @(negedge CLK_SYS); n++; end
    chk("wake_len", n, 20);
    chk("pre_te", {31'd0, timing_en}, 32'd1);
    chk("pre_ready", {31'd0, ready}, 32'd0);
    wait_state(3'd4, 2500, "ramp_entry");
    for (int i = 0; i < 4; i++) begin
      after_tick();
      pwm_hi(hi);
      chk($sformatf("ramp_duty%0d", i), hi, up_duty[i]);
      chk($sformatf("ramp_state%0d", i), {29'd0, state}, up_st[i]);
    end
    chk("on_ready", {31'd0, ready}, 32'd1);

    // Shutdown from ON
    en = 1'b0;
    @(negedge CLK_SYS);
    chk("down_state", {29'd0, state}, 32'd6);
    chk("down_ready", {31'd0, ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      after_tick();
      pwm_hi(hi);
      chk($sformatf("down_duty%0d", i), hi, dn_duty[i]);
      chk($sformatf("down_state%0d", i), {29'd0, state}, dn_st[i]);
    end
    chk("post_te", {31'd0, timing_en}, 32'd1);
    after_tick();
    chk("off_state", {29'd0, state}, 32'd0);
    chk("off_te", {31'd0, timing_en}, 32'd0);
    chk("off_lcd_rst_n", {31'd0, lcd_rst_n}, 32'd0);
    pwm_hi(hi);
    chk("off_pwm_zero", hi, 0);

    // Abort during WAKE
    te0 = te_cnt;
    en  = 1'b1;
    wait_state(3'd2, 50, "wake_again");
    repeat (5) @(negedge CLK_SYS);
    en = 1'b0;
    @(negedge CLK_SYS);
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_lcd_rst_n", {31'd0, lcd_rst_n}, 32'd0);
    repeat (3) @(negedge CLK_SYS);
    chk("abort_te_never", te_cnt - te0, 0);

    // Abort in RAMP at duty 128
    en = 1'b1;
    wait_state(3'd4, 8000, "ramp2_entry");
    after_tick();
    pwm_hi(hi);
    chk("ramp2_duty64", hi, 64);
    after_tick();
    pwm_hi(hi);
    chk("ramp2_duty128", hi, 128);
    en = 1'b0;
    @(negedge CLK_SYS);
    chk("ramp2_down", {29'd0, state}, 32'd6);
    pwm_hi(hi);
    chk("ramp2_hold128", hi, 128);
    after_tick();
    pwm_hi(hi);
    chk("ramp2_dn64", hi, 64);
    chk("ramp2_dn64_state", {29'd0, state}, 32'd6);
    after_tick();
    pwm_hi(hi);
    chk("ramp2_dn0", hi, 0);
    chk("ramp2_post", {29'd0, state}, 32'd7);
    wait_state(3'd0, 2000, "ramp2_off");

    // Asynchronous reset in ON, then restart
    en = 1'b1;
    wait_state(3'd5, 8000, "on_again");
    chk("on_again_ready", {31'd0, ready}, 32'd1);
    @(negedge CLK_SYS);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_lcd_rst_n", {31'd0, lcd_rst_n}, 32'd0);
    chk("arst_te", {31'd0, timing_en}, 32'd0);
    chk("arst_bl_pwm", {31'd0, bl_pwm}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd0);
    repeat (3) @(negedge CLK_SYS);
    rst = 1'b1;
    wait_state(3'd1, 5, "restart_rst");
    wait_state(3'd5, 8000, "restart_on");
    repeat (2) @(negedge CLK_SYS);
    pwm_hi(hi);
    chk("restart_duty255", hi, 255);
    chk("restart_ready", {31'd0, ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
